// File: rtl/decade_timer_pkg.sv
// Shared types for the decade timer: FSM state encoding and BCD digit type.
package decade_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

endpackage

// File: rtl/decade_timer_ctrl_bcd_digit.sv
// One MOD-10 decade digit; increments on inc and wraps 9 -> 0.
module bcd_digit
    import decade_timer_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output bcd_t q,
    output logic at_max
);

    assign at_max = (q == BCD_MAX);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc) begin
            q <= at_max ? '0 : q + 4'd1;
        end
    end

endmodule

// File: rtl/decade_timer_ctrl.sv
// Command FSM and prescaler driving a ripple-enable chain of BCD digits,
// with lap capture and a sticky overflow flag.
module decade_timer_ctrl
    import decade_timer_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    input  logic                  lap,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic [4*DIGITS-1:0]   lap_bcd,
    output logic                  running,
    output logic                  tick,
    output logic                  overflow,
    output logic [1:0]            state
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    state_t        st;
    logic [PW-1:0] presc;
    logic [DIGITS:0]   carry;
    logic [DIGITS-1:0] at_max;

    // Commands are single-cycle strobes sampled at the rising edge; there is
    // no backpressure. Priority is clear > stop > start, so a stop cancels a
    // coincident start in every state.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            st      <= IDLE;
            presc   <= '0;
            running <= 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    if (start && !stop) begin
                        st      <= RUN;
                        presc   <= '0;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    presc <= tick ? '0 : presc + PW'(1);
                    if (stop) begin
                        st      <= PAUSE;
                        running <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (start && !stop) begin
                        st      <= RUN;
                        running <= 1'b1;
                    end
                end
                default: begin
                    st      <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

    assign tick  = (st == RUN) && (presc == PRE_LAST);
    assign state = st;

    // Digit k advances only when tick is set and every lower digit sits at 9.
    assign carry[0] = tick;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_digit u_digit (
            .clk    (clk),
            .rst    (rst),
            .clr    (clear),
            .inc    (carry[k]),
            .q      (count_bcd[4*k +: 4]),
            .at_max (at_max[k])
        );
        assign carry[k+1] = carry[k] & at_max[k];
    end

    // Lap captures the pre-edge count; the carry out of the top digit is the
    // all-9s wrap that latches overflow.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            lap_bcd  <= '0;
            overflow <= 1'b0;
        end else begin
            if (lap && st != IDLE) begin
                lap_bcd <= count_bcd;
            end
            if (carry[DIGITS]) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: doc/decade_timer_ctrl.md
# decade_timer_ctrl

Sequencing controller for a chain of MOD-10 decade counters. Forms a multi-digit BCD timer/stopwatch. A command FSM (start/stop/clear/lap) gates a clock prescaler. The prescaler tick drives a ripple-enable chain of decade digits with carry, lap capture and sticky overflow. The block sits between the user control logic and the BCD display/readout path.

## Interface
- DIGITS, 4, number of cascaded decade digits (1..8)
- PRESCALE, 10, clk cycles per timer tick (>=2)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- start  in  1  single-cycle pulse: begin/resume counting
- stop  in  1  single-cycle pulse: pause counting
- clear  in  1  single-cycle pulse: zero count, lap, overflow; return to IDLE
- lap  in  1  single-cycle pulse: capture current count into lap_bcd
- count_bcd  out  4*DIGITS  live count; digit k at bits [4k+3:4k], digit 0 least significant
- lap_bcd  out  4*DIGITS  last captured count
- running  out  1  high while state is RUN
- tick  out  1  prescaler terminal pulse (combinational from registers)
- overflow  out  1  sticky: count wrapped past all-9s
- state  out  2  FSM state, encoded IDLE=0, RUN=1, PAUSE=2

## Operation
- FSM states:
  - IDLE: start -> RUN.
  - RUN: stop -> PAUSE; start ignored.
  - PAUSE: start -> RUN.
  - Any state: clear -> IDLE.
- Command priority when several are asserted in one cycle: clear > stop > start. lap is independent of the other three, except that clear wins over lap.
- Prescaler:
  - Counts 0..PRESCALE-1, advancing only in RUN, and wraps to 0.
  - Holds its value in PAUSE.
  - Forced to 0 by clear and on the IDLE->RUN transition.
- tick = (state==RUN) && (prescaler==PRESCALE-1).
- Digit chain: digit 0 increments when tick=1. Digit k increments when tick=1 and digits 0..k-1 all equal 9. A digit at 9 that increments wraps to 0. Digit values never exceed 9.
- Overflow: tick=1 while all digits equal 9 sets overflow=1 and wraps the count to all zeros. overflow stays set until clear or rst.
- Lap:
  - lap=1 in RUN or PAUSE loads lap_bcd with the pre-edge count_bcd value, not the incremented value.
  - lap in IDLE is ignored.
  - lap together with clear: clear wins and lap_bcd becomes 0.
- stop and tick in the same cycle: the tick's increment still applies at that edge, and the state goes to PAUSE.

## Timing
- Reset (rst=0 at an edge) sets state=IDLE, prescaler=0, count_bcd=0, lap_bcd=0, overflow=0, running=0, tick=0. All commands are ignored while rst=0.
- All commands are sampled at the rising edge; their effect is visible in registered outputs the following cycle.
- A start sampled at edge E0 gives running=1 after E0, tick high in the cycle after edge E(PRESCALE-1), and count_bcd=1 after edge E(PRESCALE).
- Steady state: one tick every PRESCALE cycles in RUN. Pause/resume does not lose the partial prescaler count.
- Reset mid-count has the same effect as power-on reset. The clear command behaves identically except that it is a registered command rather than a reset.

## Structure
- Package decade_timer_pkg contains:
  - typedef enum logic [1:0] state_t {IDLE, RUN, PAUSE}
  - typedef logic [3:0] bcd_t
  - localparam bcd_t BCD_MAX = 4'd9
- Sub-module bcd_digit, instantiated DIGITS times via generate:
  - Inputs: clk, rst, clr, inc.
  - Outputs: q (bcd_t), at_max (q==9).
  - Carry is formed in the parent as an AND-chain of at_max.
- The FSM and prescaler live in decade_timer_ctrl.

## Test plan
- Reset: hold rst=0 for 3 cycles with start=1 -> all outputs 0, state=IDLE.
- Counting (PRESCALE=10, DIGITS=4): start, run 250 cycles -> count_bcd=16'h0025, tick period exactly 10 cycles, no digit >9.
- Pause/resume: start, stop after 57 cycles, wait 40, start, run 43 more -> count_bcd=16'h0010. The prescaler value is preserved across the pause.
- Overflow (PRESCALE=2, DIGITS=2): start, run 200 cycles -> count wraps 99->00 at the 100th tick, overflow=1 and remains set. clear -> overflow=0, count=0, IDLE.
- Lap: lap in the cycle where count=0x0013 and tick=1 -> lap_bcd=0x0013 and count becomes 0x0014. lap in IDLE -> lap_bcd unchanged.
- Simultaneous commands: start+stop+clear in RUN -> IDLE, zeroed outputs. stop+tick -> final increment applied, state=PAUSE.
